id_operand_stage: RTL and testbench
===================================

Name: id_operand_stage

Overview:
- Parametrised successor decode/operand stage for the 5-stage MIPS core; sits between IF and EX.
- Owns the IF→ID pipeline register and the valid/allowin handshake.
- Reads two register-file ports and resolves operands through an N-way bypass network from downstream producers.
- Generates a load-use interlock internally and resolves beq/bne/jal/jr in ID using bypassed operands.

Parameters:
- DATA_W, 32, register/operand width.
- RADDR_W, 5, register address width.
- NUM_FWD, 3, number of bypass sources; index 0 = nearest (EX), ascending = older (MEM, WB).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of ID contents
- fs_to_ds_valid  in  1  IF has an instruction
- fs_inst  in  32  instruction from IF
- fs_pc  in  32  PC from IF
- ds_allowin  out  1  ID can accept
- es_allowin  in  1  EX can accept
- ds_to_es_valid  out  1  ID hands off
- ds_inst  out  32  registered instruction
- ds_pc  out  32  registered PC
- rs_value  out  DATA_W  resolved rs operand
- rt_value  out  DATA_W  resolved rt operand
- rf_raddr1  out  RADDR_W  rs field
- rf_raddr2  out  RADDR_W  rt field
- rf_rdata1  in  DATA_W  regfile port 1
- rf_rdata2  in  DATA_W  regfile port 2
- fwd_we  in  NUM_FWD  producer i valid and writes a GPR
- fwd_addr  in  NUM_FWD*RADDR_W  producer i destination
- fwd_data  in  NUM_FWD*DATA_W  producer i result
- fwd_rdy  in  NUM_FWD  producer i result available this cycle (0 for load in EX)
- br_taken  out  1  redirect IF
- br_target  out  32  redirect PC

Behaviour:
- Async reset (resetn=0): ds_valid=0, ds_inst=0, ds_pc=0. Consequently ds_to_es_valid=0 and br_taken=0.
- Register update: if flush, ds_valid<=0 next edge; flush overrides a simultaneous load. Otherwise, when ds_allowin, ds_valid<=fs_to_ds_valid. ds_inst/ds_pc load only when fs_to_ds_valid && ds_allowin && !flush.
- ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
- ds_to_es_valid = ds_valid && ds_ready_go && !flush.
- Operand use:
  - use_rs for all instructions except sll/srl/sra/jal.
  - use_rt for R-type except jr, and for sw/beq/bne.
  - Register 0 is never bypassed and never stalls; its value is always 0.
- Bypass selection:
  - For each operand, select the lowest index i with fwd_we[i] && fwd_addr[i]==field && field!=0.
  - Matching producer with fwd_rdy[i]=1 → operand = fwd_data[i].
  - No match → operand = regfile read data.
  - Older matches are ignored once a nearer one hits.
- Interlock: ds_ready_go=0 when a used operand's selected producer has fwd_rdy=0. No counter; re-evaluated every cycle.
- Branch resolution (combinational, gated by ds_valid && ds_ready_go && !flush):
  - beq taken if rs==rt; bne taken if rs!=rt.
  - jal and jr always taken.
  - Targets:
    - beq/bne: ds_pc+4+sext(imm)<<2.
    - jal: {(ds_pc+4)[31:28], jidx, 2'b00}.
    - jr: rs_value.
  - br_target = 0 when br_taken=0.
- Widths: comparisons are DATA_W wide. PC arithmetic is 32-bit and wraps modulo 2^32.
- Stall with es_allowin=0: hold all registers. Outputs stay stable. br_taken must not pulse twice for one instruction; it is valid only on the handoff cycle (ds_to_es_valid && es_allowin).
- Reset mid-stall: all state clears immediately.

Optional Feature:
- Macro ID_STALL_PERF_EN.
- Defined:
  - Adds output stall_cnt (32 bits), reset 0.
  - Increments by 1 each cycle ds_valid && !ds_ready_go && !flush; saturates at 0xFFFFFFFF.
  - Adds output bypass_cnt (32 bits), reset 0. Increments per handed-off instruction that used at least one bypassed operand; saturates.
- Undefined: no counters, no extra ports; functionally identical otherwise.

Test Plan:
- Reset with resetn=0 mid-stream → ds_valid=0, ds_to_es_valid=0, br_taken=0 asynchronously; after release, first fs_to_ds_valid loads next edge.
- addu $3,$1,$2 with fwd0 {we=1,addr=1,data=0x11,rdy=1} and fwd2 {addr=1,data=0x99} → rs_value=0x11 (nearest wins); rt_value=rf_rdata2.
- Load-use: fwd0 {we=1,addr=5,rdy=0}, ID holds addu using $5 → ds_ready_go=0 for 1 cycle, ds_allowin=0. Next cycle fwd1 {addr=5,data=0xABCD,rdy=1} → handoff with rs_value=0xABCD.
- beq $4,$4 at pc 0xBFC00010, imm=0xFFFF → br_taken=1, br_target=0xBFC00010.
- jr $31 while fwd1 writes $31=0x80001234 → br_target=0x80001234; with fwd0 matching $31 and rdy=0, br_taken stays 0 until resolved.
- flush asserted same cycle as fs_to_ds_valid=1 → ds_valid=0 next cycle, ds_inst unchanged. With ID_STALL_PERF_EN, 3 stall cycles → stall_cnt=3.

Source files
------------

// File: rtl/id_operand_stage_if.sv
// IF->ID->EX handshake, regfile read ports, bypass sources and branch redirect for the decode stage.
// master = decode stage side, slave = surrounding pipeline side.
interface id_operand_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int NUM_FWD = 3
);
  logic                         fs_to_ds_valid;
  logic [31:0]                  fs_inst;
  logic [31:0]                  fs_pc;
  logic                         ds_allowin;
  logic                         es_allowin;
  logic                         ds_to_es_valid;
  logic [31:0]                  ds_inst;
  logic [31:0]                  ds_pc;
  logic [DATA_W-1:0]            rs_value;
  logic [DATA_W-1:0]            rt_value;
  logic [RADDR_W-1:0]           rf_raddr1;
  logic [RADDR_W-1:0]           rf_raddr2;
  logic [DATA_W-1:0]            rf_rdata1;
  logic [DATA_W-1:0]            rf_rdata2;
  logic [NUM_FWD-1:0]           fwd_we;
  logic [NUM_FWD*RADDR_W-1:0]   fwd_addr;
  logic [NUM_FWD*DATA_W-1:0]    fwd_data;
  logic [NUM_FWD-1:0]           fwd_rdy;
  logic                         br_taken;
  logic [31:0]                  br_target;

  modport master (
    input  fs_to_ds_valid, fs_inst, fs_pc, es_allowin,
    input  rf_rdata1, rf_rdata2, fwd_we, fwd_addr, fwd_data, fwd_rdy,
    output ds_allowin, ds_to_es_valid, ds_inst, ds_pc, rs_value, rt_value,
    output rf_raddr1, rf_raddr2, br_taken, br_target
  );

  modport slave (
    output fs_to_ds_valid, fs_inst, fs_pc, es_allowin,
    output rf_rdata1, rf_rdata2, fwd_we, fwd_addr, fwd_data, fwd_rdy,
    input  ds_allowin, ds_to_es_valid, ds_inst, ds_pc, rs_value, rt_value,
    input  rf_raddr1, rf_raddr2, br_taken, br_target
  );
endinterface

// File: rtl/id_operand_stage.sv
// MIPS decode/operand stage: one register stage, operands bypassed combinationally; stalls (holds, allowin=0) on a not-ready producer or es_allowin=0.
// ID_STALL_PERF_EN adds saturating stall_cnt / bypass_cnt outputs.
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int NUM_FWD = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  id_operand_stage_if.master bus
`ifdef ID_STALL_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bypass_cnt
`endif
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;

  logic               ds_valid;
  logic [31:0]        ds_inst;
  logic [31:0]        ds_pc;
  logic               ds_ready_go;
  logic               ds_allowin;
  logic               handoff_ok;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [RADDR_W-1:0] rs_field;
  logic [RADDR_W-1:0] rt_field;
  logic               is_rtype;
  logic               is_shift_imm;
  logic               is_jr;
  logic               is_jal;
  logic               is_beq;
  logic               is_bne;
  logic               is_sw;
  logic               use_rs;
  logic               use_rt;

  logic               rs_hit;
  logic               rs_rdy;
  logic [DATA_W-1:0]  rs_fwd;
  logic               rt_hit;
  logic               rt_rdy;
  logic [DATA_W-1:0]  rt_fwd;
  logic [DATA_W-1:0]  rs_value;
  logic [DATA_W-1:0]  rt_value;

  logic [31:0]        pc_plus4;
  logic [31:0]        br_offset;
  logic               operands_eq;
  logic               br_cond;
  logic               br_taken;
  logic [31:0]        br_target;

  // Returns {hit, rdy, data} of the nearest matching producer; $0 never matches.
  function automatic logic [DATA_W+1:0] bypass_pick(
    input logic [RADDR_W-1:0]         field,
    input logic [NUM_FWD-1:0]         we,
    input logic [NUM_FWD*RADDR_W-1:0] addr,
    input logic [NUM_FWD*DATA_W-1:0]  data,
    input logic [NUM_FWD-1:0]         rdy
  );
    logic [DATA_W+1:0] r;
    r = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (we[i] && (addr[i*RADDR_W +: RADDR_W] == field)) begin
        r = {1'b1, rdy[i], data[i*DATA_W +: DATA_W]};
      end
    end
    if (field == '0) begin
      r = '0;
    end
    return r;
  endfunction

  // Pipeline register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid <= 1'b0;
      ds_inst  <= 32'h0;
      ds_pc    <= 32'h0;
    end else begin
      if (flush) begin
        ds_valid <= 1'b0;
      end else if (ds_allowin) begin
        ds_valid <= bus.fs_to_ds_valid;
      end
      if (bus.fs_to_ds_valid && ds_allowin && !flush) begin
        ds_inst <= bus.fs_inst;
        ds_pc   <= bus.fs_pc;
      end
    end
  end

  // Decode
  assign opcode       = ds_inst[31:26];
  assign funct        = ds_inst[5:0];
  assign rs_field     = RADDR_W'(ds_inst[25:21]);
  assign rt_field     = RADDR_W'(ds_inst[20:16]);
  assign is_rtype     = (opcode == OP_SPECIAL);
  assign is_shift_imm = is_rtype && ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA));
  assign is_jr        = is_rtype && (funct == FN_JR);
  assign is_jal       = (opcode == OP_JAL);
  assign is_beq       = (opcode == OP_BEQ);
  assign is_bne       = (opcode == OP_BNE);
  assign is_sw        = (opcode == OP_SW);
  assign use_rs       = !is_shift_imm && !is_jal;
  assign use_rt       = (is_rtype && !is_jr) || is_sw || is_beq || is_bne;

  // Bypass network
  always_comb begin
    {rs_hit, rs_rdy, rs_fwd} = bypass_pick(rs_field, bus.fwd_we, bus.fwd_addr, bus.fwd_data, bus.fwd_rdy);
    {rt_hit, rt_rdy, rt_fwd} = bypass_pick(rt_field, bus.fwd_we, bus.fwd_addr, bus.fwd_data, bus.fwd_rdy);
  end

  always_comb begin
    rs_value = bus.rf_rdata1;
    rt_value = bus.rf_rdata2;
    if (rs_field == '0) begin
      rs_value = '0;
    end else if (rs_hit && rs_rdy) begin
      rs_value = rs_fwd;
    end
    if (rt_field == '0) begin
      rt_value = '0;
    end else if (rt_hit && rt_rdy) begin
      rt_value = rt_fwd;
    end
  end

  // Load-use interlock: a used operand whose nearest producer has no result yet
  assign ds_ready_go = !((use_rs && rs_hit && !rs_rdy) || (use_rt && rt_hit && !rt_rdy));
  assign ds_allowin  = !ds_valid || (ds_ready_go && bus.es_allowin);
  assign handoff_ok  = ds_valid && ds_ready_go && !flush;

  // Branch resolution; redirect only on the handoff cycle so a held branch fires once
  assign pc_plus4    = ds_pc + 32'd4;
  assign br_offset   = {{14{ds_inst[15]}}, ds_inst[15:0], 2'b00};
  assign operands_eq = (rs_value == rt_value);
  assign br_cond     = (is_beq && operands_eq) || (is_bne && !operands_eq) || is_jal || is_jr;
  assign br_taken    = handoff_ok && bus.es_allowin && br_cond;

  always_comb begin
    br_target = 32'h0;
    if (br_taken) begin
      if (is_jal) begin
        br_target = {pc_plus4[31:28], ds_inst[25:0], 2'b00};
      end else if (is_jr) begin
        br_target = 32'(rs_value);
      end else begin
        br_target = pc_plus4 + br_offset;
      end
    end
  end

  assign bus.ds_allowin     = ds_allowin;
  assign bus.ds_to_es_valid = handoff_ok;
  assign bus.ds_inst        = ds_inst;
  assign bus.ds_pc          = ds_pc;
  assign bus.rs_value       = rs_value;
  assign bus.rt_value       = rt_value;
  assign bus.rf_raddr1      = rs_field;
  assign bus.rf_raddr2      = rt_field;
  assign bus.br_taken       = br_taken;
  assign bus.br_target      = br_target;

`ifdef ID_STALL_PERF_EN
  logic used_bypass;
  assign used_bypass = (use_rs && rs_hit) || (use_rt && rt_hit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt  <= 32'h0;
      bypass_cnt <= 32'h0;
    end else begin
      if (ds_valid && !ds_ready_go && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (handoff_ok && bus.es_allowin && used_bypass && (bypass_cnt != 32'hFFFF_FFFF)) begin
        bypass_cnt <= bypass_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed vector bench for id_operand_stage plus hand sequences for reset, load-use, flush and counters.
module tb_id_operand_stage;

  logic clk = 1'b0;
  logic resetn;
  logic flush;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  id_operand_stage_if #(.DATA_W(32), .RADDR_W(5), .NUM_FWD(3)) ifc ();

`ifdef ID_STALL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bypass_cnt;
`endif

  id_operand_stage #(.DATA_W(32), .RADDR_W(5), .NUM_FWD(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .bus       (ifc)
`ifdef ID_STALL_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bypass_cnt(bypass_cnt)
`endif
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic [2:0]  we;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  rdy;
    logic        es;
    logic        chk_rs;
    logic        chk_rt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        go;
    logic        allowin;
    logic        br;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(
    input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rf1, input logic [31:0] rf2,
    input logic [2:0] we, input logic [14:0] addr, input logic [95:0] data, input logic [2:0] rdy,
    input logic es, input logic chk_rs, input logic chk_rt, input logic [31:0] rs, input logic [31:0] rt,
    input logic go, input logic allowin, input logic br, input logic [31:0] tgt);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rf1 = rf1; v.rf2 = rf2;
    v.we = we; v.addr = addr; v.data = data; v.rdy = rdy; v.es = es;
    v.chk_rs = chk_rs; v.chk_rt = chk_rt; v.rs = rs; v.rt = rt;
    v.go = go; v.allowin = allowin; v.br = br; v.tgt = tgt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_fwd(input logic [2:0] we, input logic [14:0] addr, input logic [95:0] data,
                         input logic [2:0] rdy);
    ifc.fwd_we   = we;
    ifc.fwd_addr = addr;
    ifc.fwd_data = data;
    ifc.fwd_rdy  = rdy;
  endtask

  // Leaves the new instruction held in ID, returning at the following negedge.
  task automatic load_inst(input logic [31:0] inst, input logic [31:0] pc);
    @(negedge clk);
    set_fwd(3'b000, 15'h0, 96'h0, 3'b000);
    ifc.es_allowin     = 1'b1;
    ifc.fs_to_ds_valid = 1'b1;
    ifc.fs_inst        = inst;
    ifc.fs_pc          = pc;
    @(negedge clk);
    ifc.fs_to_ds_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] addu_135;
    logic [31:0] addu_356;
    logic [31:0] jal_inst;
    logic [31:0] jr_31;
    logic [31:0] bne_45;

    addu_135 = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    addu_356 = rtype(5'd5, 5'd6, 5'd3, 5'd0, 6'h21);
    jal_inst = {6'h03, 26'h3FF_FFFF};
    jr_31    = rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    bne_45   = itype(6'h05, 5'd4, 5'd5, 16'd3);

    //                inst                                  pc            rf1           rf2          we      addr                     data                                             rdy    es  crs crt rs            rt           go al br tgt
    vecs[0]  = mk(addu_135,                              32'h0,        32'hAAAA0001, 32'h2222,    3'b101, {5'd1, 5'd0, 5'd1},      {32'h99, 32'h0, 32'h11},                         3'b101, 1, 1, 1, 32'h11,       32'h2222,    1, 1, 0, 32'h0);
    vecs[1]  = mk(addu_135,                              32'h4,        32'hAAAA0001, 32'h2222,    3'b110, {5'd1, 5'd2, 5'd0},      {32'h77, 32'h55, 32'h0},                         3'b110, 1, 1, 1, 32'h77,       32'h55,      1, 1, 0, 32'h0);
    vecs[2]  = mk(rtype(5'd0, 5'd2, 5'd3, 5'd0, 6'h21),  32'h8,        32'hDEAD,     32'h1234,    3'b001, {5'd0, 5'd0, 5'd0},      {32'h0, 32'h0, 32'h5},                           3'b000, 1, 1, 1, 32'h0,        32'h1234,    1, 1, 0, 32'h0);
    vecs[3]  = mk(rtype(5'd5, 5'd2, 5'd3, 5'd4, 6'h00),  32'hC,        32'h1111,     32'h2222,    3'b001, {5'd0, 5'd0, 5'd5},      {32'h0, 32'h0, 32'h0},                           3'b000, 1, 0, 1, 32'h0,        32'h2222,    1, 1, 0, 32'h0);
    vecs[4]  = mk(itype(6'h2b, 5'd4, 5'd5, 16'd8),       32'h10,       32'h100,      32'h3333,    3'b001, {5'd0, 5'd0, 5'd5},      {32'h0, 32'h0, 32'h0},                           3'b000, 1, 1, 0, 32'h100,      32'h0,       0, 0, 0, 32'h0);
    vecs[5]  = mk(itype(6'h04, 5'd4, 5'd4, 16'hFFFF),    32'hBFC00010, 32'h7,        32'h7,       3'b000, 15'h0,                   96'h0,                                           3'b000, 1, 1, 1, 32'h7,        32'h7,       1, 1, 1, 32'hBFC00010);
    vecs[6]  = mk(itype(6'h04, 5'd4, 5'd5, 16'd3),       32'h1000,     32'h1,        32'h2,       3'b000, 15'h0,                   96'h0,                                           3'b000, 1, 1, 1, 32'h1,        32'h2,       1, 1, 0, 32'h0);
    vecs[7]  = mk(bne_45,                                32'h1000,     32'h1,        32'h2,       3'b000, 15'h0,                   96'h0,                                           3'b000, 1, 1, 1, 32'h1,        32'h2,       1, 1, 1, 32'h1010);
    vecs[8]  = mk(bne_45,                                32'h1000,     32'h1,        32'h2,       3'b001, {5'd0, 5'd0, 5'd5},      {32'h0, 32'h0, 32'h1},                           3'b001, 1, 1, 1, 32'h1,        32'h1,       1, 1, 0, 32'h0);
    vecs[9]  = mk(jal_inst,                              32'h00400000, 32'h0,        32'h0,       3'b001, {5'd0, 5'd0, 5'd31},     {32'h0, 32'h0, 32'h0},                           3'b000, 1, 0, 0, 32'h0,        32'h0,       1, 1, 1, 32'h0FFFFFFC);
    vecs[10] = mk(jr_31,                                 32'h20,       32'h0,        32'h0,       3'b010, {5'd0, 5'd31, 5'd0},     {32'h0, 32'h80001234, 32'h0},                    3'b010, 1, 1, 1, 32'h80001234, 32'h0,       1, 1, 1, 32'h80001234);
    vecs[11] = mk(jr_31,                                 32'h20,       32'h0,        32'h0,       3'b011, {5'd0, 5'd31, 5'd31},    {32'h0, 32'h80001234, 32'h0},                    3'b010, 1, 0, 0, 32'h0,        32'h0,       0, 0, 0, 32'h0);
    vecs[12] = mk(itype(6'h04, 5'd4, 5'd4, 16'd2),       32'h2000,     32'h9,        32'h9,       3'b000, 15'h0,                   96'h0,                                           3'b000, 0, 1, 1, 32'h9,        32'h9,       1, 0, 0, 32'h0);
    vecs[13] = mk(itype(6'h04, 5'd4, 5'd4, 16'd1),       32'hFFFFFFFC, 32'h3,        32'h3,       3'b000, 15'h0,                   96'h0,                                           3'b000, 1, 1, 1, 32'h3,        32'h3,       1, 1, 1, 32'h4);
    vecs[14] = mk({6'h03, 26'h0000010},                  32'hAFFFFFFC, 32'h0,        32'h0,       3'b000, 15'h0,                   96'h0,                                           3'b000, 1, 0, 0, 32'h0,        32'h0,       1, 1, 1, 32'hB0000040);

    // Reset state
    resetn = 1'b0;
    flush  = 1'b0;
    ifc.fs_to_ds_valid = 1'b0;
    ifc.fs_inst   = 32'h0;
    ifc.fs_pc     = 32'h0;
    ifc.es_allowin = 1'b1;
    ifc.rf_rdata1 = 32'h0;
    ifc.rf_rdata2 = 32'h0;
    set_fwd(3'b000, 15'h0, 96'h0, 3'b000);
    #12;
    check("rst_valid",   {31'b0, ifc.ds_to_es_valid}, 32'd0);
    check("rst_br",      {31'b0, ifc.br_taken},       32'd0);
    check("rst_inst",    ifc.ds_inst,                 32'h0);
    check("rst_pc",      ifc.ds_pc,                   32'h0);
    check("rst_allowin", {31'b0, ifc.ds_allowin},     32'd1);
    @(negedge clk);
    resetn = 1'b1;

    // Asynchronous reset while a jal sits in ID
    load_inst(jal_inst, 32'h00400000);
    #1;
    check("pre_rst_br", {31'b0, ifc.br_taken}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("arst_br",    {31'b0, ifc.br_taken},       32'd0);
    check("arst_valid", {31'b0, ifc.ds_to_es_valid}, 32'd0);
    check("arst_inst",  ifc.ds_inst,                 32'h0);
    check("arst_pc",    ifc.ds_pc,                   32'h0);
    @(negedge clk);
    resetn = 1'b1;
    ifc.fs_to_ds_valid = 1'b1;
    ifc.fs_inst = addu_135;
    ifc.fs_pc   = 32'h100;
    @(posedge clk);
    #1;
    check("post_rst_inst",  ifc.ds_inst,                 addu_135);
    check("post_rst_valid", {31'b0, ifc.ds_to_es_valid}, 32'd1);
    @(negedge clk);
    ifc.fs_to_ds_valid = 1'b0;

    // Vector table
    for (int i = 0; i < 15; i++) begin
      load_inst(vecs[i].inst, vecs[i].pc);
      ifc.rf_rdata1  = vecs[i].rf1;
      ifc.rf_rdata2  = vecs[i].rf2;
      ifc.es_allowin = vecs[i].es;
      set_fwd(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].rdy);
      #1;
      check($sformatf("v%0d_pc", i),      ifc.ds_pc,                   vecs[i].pc);
      check($sformatf("v%0d_go", i),      {31'b0, ifc.ds_to_es_valid}, {31'b0, vecs[i].go});
      check($sformatf("v%0d_allowin", i), {31'b0, ifc.ds_allowin},     {31'b0, vecs[i].allowin});
      check($sformatf("v%0d_br", i),      {31'b0, ifc.br_taken},       {31'b0, vecs[i].br});
      check($sformatf("v%0d_tgt", i),     ifc.br_target,               vecs[i].tgt);
      if (vecs[i].chk_rs) check($sformatf("v%0d_rs", i), ifc.rs_value, vecs[i].rs);
      if (vecs[i].chk_rt) check($sformatf("v%0d_rt", i), ifc.rt_value, vecs[i].rt);
    end

    // Load-use: one stall cycle, IF offers a new instruction meanwhile, then resolve from MEM
    load_inst(addu_356, 32'h300);
    ifc.rf_rdata1 = 32'h5555;
    ifc.rf_rdata2 = 32'h6666;
    set_fwd(3'b001, {5'd0, 5'd0, 5'd5}, 96'h0, 3'b000);
    ifc.fs_to_ds_valid = 1'b1;
    ifc.fs_inst = jal_inst;
    ifc.fs_pc   = 32'h304;
    #1;
    check("lu_stall_go",      {31'b0, ifc.ds_to_es_valid}, 32'd0);
    check("lu_stall_allowin", {31'b0, ifc.ds_allowin},     32'd0);
    @(negedge clk);
    ifc.fs_to_ds_valid = 1'b0;
    set_fwd(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hABCD, 32'h0}, 3'b010);
    #1;
    check("lu_hold_inst", ifc.ds_inst,                 addu_356);
    check("lu_go",        {31'b0, ifc.ds_to_es_valid}, 32'd1);
    check("lu_rs",        ifc.rs_value,                32'hABCD);
    check("lu_rt",        ifc.rt_value,                32'h6666);

    // Flush kills a held jal and overrides a simultaneous load
    load_inst(jal_inst, 32'h00400000);
    flush = 1'b1;
    ifc.fs_to_ds_valid = 1'b1;
    ifc.fs_inst = addu_135;
    ifc.fs_pc   = 32'h400;
    #1;
    check("flush_go", {31'b0, ifc.ds_to_es_valid}, 32'd0);
    check("flush_br", {31'b0, ifc.br_taken},       32'd0);
    @(negedge clk);
    flush = 1'b0;
    ifc.fs_to_ds_valid = 1'b0;
    #1;
    check("flush_valid",   {31'b0, ifc.ds_to_es_valid}, 32'd0);
    check("flush_inst",    ifc.ds_inst,                 jal_inst);
    check("flush_allowin", {31'b0, ifc.ds_allowin},     32'd1);

`ifdef ID_STALL_PERF_EN
    @(negedge clk);
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    load_inst(addu_356, 32'h500);
    set_fwd(3'b001, {5'd0, 5'd0, 5'd5}, 96'h0, 3'b000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stall_cnt", stall_cnt, 32'd3);
    set_fwd(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'h1, 32'h0}, 3'b010);
    @(posedge clk);
    #1;
    check("bypass_cnt", bypass_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
